// File: rtl/cpu_pkg.sv
// Shared CPU constants: PC width, return-stack depth and the call/return
// opcode encodings used by both the control unit and the return stack.
package cpu_pkg;

  localparam int PC_W         = 10;
  localparam int RSTACK_DEPTH = 16;

  // Low two bits are don't-care; match with ==? only.
  localparam logic [5:0] OP_PUSH = 6'b1110??;
  localparam logic [5:0] OP_POP  = 6'b1111??;

  function automatic logic is_call(input logic [5:0] op);
    return op ==? OP_PUSH;
  endfunction

  function automatic logic is_ret(input logic [5:0] op);
    return op ==? OP_POP;
  endfunction

endpackage

// File: rtl/stack_regfile.sv
// DEPTH x AW register array: one synchronous write port, one combinational
// read port. Contents are deliberately not reset.
module stack_regfile #(
  parameter int DEPTH = 16,
  parameter int AW    = 10,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [AW-1:0] wdata,
  input  logic [PW-1:0] raddr,
  output logic [AW-1:0] rdata
);

  logic [DEPTH-1:0][AW-1:0] mem;

  // Single write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/return_stack.sv
// Return-address LIFO. sp is the occupancy and the next free slot; the top
// entry is read combinationally so a return can redirect the PC in the same
// cycle as the pop strobe.
module return_stack
  import cpu_pkg::*;
#(
  parameter int DEPTH = RSTACK_DEPTH,
  parameter int AW    = PC_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [AW-1:0]              ret_in,
  output logic [AW-1:0]              ret_out,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       ovf,
  output logic                       unf
);

  localparam int PW  = $clog2(DEPTH);
  localparam int SPW = PW + 1;

  logic [SPW-1:0] sp;
  logic [PW-1:0]  top_idx;
  logic [PW-1:0]  waddr;
  logic [AW-1:0]  rdata;
  logic           we, inc, dec, set_ovf, set_unf;

  assign empty = (sp == '0);
  assign full  = (sp == SPW'(DEPTH));
  assign count = sp;

  // When full, sp's low bits are 0 so top_idx wraps to DEPTH-1 as wanted.
  // When empty it also wraps, but ret_out is gated so that read is hidden.
  assign top_idx = sp[PW-1:0] - 1'b1;

  // Decode push/pop into write strobe and pointer moves.
  always_comb begin
    we      = 1'b0;
    waddr   = sp[PW-1:0];
    inc     = 1'b0;
    dec     = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    unique case ({push, pop})
      2'b10: begin
        we      = !full;
        inc     = !full;
        set_ovf = full;
      end
      2'b01: begin
        dec     = !empty;
        set_unf = empty;
      end
      2'b11: begin
        // Replace top; on an empty stack this degenerates to a plain push.
        we    = 1'b1;
        inc   = empty;
        waddr = empty ? sp[PW-1:0] : top_idx;
      end
      default: ;
    endcase
  end

  // Pointer and sticky flags; reset wins over any operation this cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sp  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (inc)      sp <= sp + 1'b1;
      else if (dec) sp <= sp - 1'b1;
      if (set_ovf)  ovf <= 1'b1;
      if (set_unf)  unf <= 1'b1;
    end
  end

  stack_regfile #(.DEPTH(DEPTH), .AW(AW)) u_rf (
    .clk   (clk),
    .we    (we && reset_n),
    .waddr (waddr),
    .wdata (ret_in),
    .raddr (top_idx),
    .rdata (rdata)
  );

  assign ret_out = empty ? '0 : rdata;

endmodule

// File: tb/tb_return_stack.sv
// Directed bench for return_stack: queue-based LIFO reference checked every
// cycle, plus literal expectations at the points of interest.
module tb_return_stack;

  localparam int DEPTH = 16;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          push = 1'b0, pop = 1'b0;
  logic [AW-1:0] ret_in = '0;
  logic [AW-1:0] ret_out;
  logic [4:0]    count;
  logic          empty, full, ovf, unf;

  int tests = 0;
  int fails = 0;

  return_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .ret_in(ret_in),
    .ret_out(ret_out), .count(count), .empty(empty), .full(full),
    .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  // Reference: a queue whose back is the top of stack.
  int m_q[$];
  bit m_ovf, m_unf, m_valid;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_q.delete();
      m_ovf   = 0;
      m_unf   = 0;
      m_valid = 1;
    end else if (m_valid) begin
      if (push && pop) begin
        if (m_q.size() == 0) m_q.push_back(int'(ret_in));
        else                 m_q[m_q.size()-1] = int'(ret_in);
      end else if (push) begin
        if (m_q.size() == DEPTH) m_ovf = 1;
        else                     m_q.push_back(int'(ret_in));
      end else if (pop) begin
        if (m_q.size() == 0) m_unf = 1;
        else                 void'(m_q.pop_back());
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the reference once it has seen reset.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_count", 32'(count), 32'(m_q.size()));
      chk("m_empty", 32'(empty), 32'(m_q.size() == 0));
      chk("m_full",  32'(full),  32'(m_q.size() == DEPTH));
      chk("m_ret",   32'(ret_out), (m_q.size() == 0) ? 32'd0 : 32'(m_q[m_q.size()-1]));
      chk("m_ovf",   32'(ovf), 32'(m_ovf));
      chk("m_unf",   32'(unf), 32'(m_unf));
    end
  end

  // Apply one cycle of inputs; returns at the following negedge, before the
  // edge that consumes them.
  task automatic cyc(input bit r, input bit pu, input bit po, input logic [AW-1:0] d);
    @(posedge clk); #1;
    reset_n = r; push = pu; pop = po; ret_in = d;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1, 0, 0, '0);
  endtask

  initial begin
    // Reset while a push is requested: push must be discarded.
    cyc(0, 1, 0, 10'h3FF);
    idle();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full",  32'(full), 0);
    chk("rst_ret",   32'(ret_out), 0);
    chk("rst_ovf",   32'(ovf), 0);
    chk("rst_unf",   32'(unf), 0);

    // LIFO order, zero-latency pop.
    cyc(1, 1, 0, 10'h010);
    cyc(1, 1, 0, 10'h020);
    cyc(1, 1, 0, 10'h030);
    cyc(1, 0, 1, '0); chk("pop1", 32'(ret_out), 32'h030);
    cyc(1, 0, 1, '0); chk("pop2", 32'(ret_out), 32'h020);
    cyc(1, 0, 1, '0); chk("pop3", 32'(ret_out), 32'h010);
    idle();
    chk("lifo_empty", 32'(empty), 1);
    chk("lifo_unf",   32'(unf), 0);

    // Fill, then overflow.
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, 0, AW'(10'h100 + i));
    idle();
    chk("fill_full",  32'(full), 1);
    chk("fill_count", 32'(count), 16);
    cyc(1, 1, 0, 10'h2AA);
    idle();
    chk("ovf_flag",  32'(ovf), 1);
    chk("ovf_ret",   32'(ret_out), 32'h10F);
    chk("ovf_count", 32'(count), 16);

    // Underflow after reset.
    cyc(0, 0, 0, '0);
    cyc(1, 0, 1, '0);
    idle();
    chk("unf_flag",  32'(unf), 1);
    chk("unf_ret",   32'(ret_out), 0);
    chk("unf_count", 32'(count), 0);
    cyc(1, 1, 0, 10'h055);
    idle();
    chk("unf_push_count", 32'(count), 1);
    chk("unf_push_ret",   32'(ret_out), 32'h055);
    chk("unf_sticky",     32'(unf), 1);

    // Simultaneous push+pop: replace top, and push on empty.
    cyc(0, 0, 0, '0);
    cyc(1, 1, 0, 10'h040);
    cyc(1, 1, 1, 10'h077);
    idle();
    chk("repl_count", 32'(count), 1);
    chk("repl_ret",   32'(ret_out), 32'h077);
    cyc(1, 0, 1, '0);
    cyc(1, 1, 1, 10'h011);
    idle();
    chk("pp_empty_count", 32'(count), 1);
    chk("pp_empty_ret",   32'(ret_out), 32'h011);
    chk("pp_empty_unf",   32'(unf), 0);

    // Mid-sequence reset.
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, AW'(i + 1));
    cyc(1, 0, 1, '0);
    cyc(1, 0, 1, '0);
    for (int i = 0; i < 14; i++) cyc(1, 1, 0, AW'(10'h200 + i)); // reaches full + ovf
    cyc(0, 1, 0, 10'h3AB);
    idle();
    chk("mid_count", 32'(count), 0);
    chk("mid_empty", 32'(empty), 1);
    chk("mid_ovf",   32'(ovf), 0);
    chk("mid_unf",   32'(unf), 0);
    cyc(1, 1, 0, 10'h001);
    idle();
    chk("mid_push_ret",   32'(ret_out), 32'h001);
    chk("mid_push_count", 32'(count), 1);

    // Mixed traffic checked by the reference only.
    for (int i = 0; i < 200; i++)
      cyc(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom));

    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/return_stack.md
# return_stack

Return-address stack for the single-cycle CPU: a LIFO that services the `push`/`pop` strobes issued by the control unit on subroutine call (`1110zz`) and return (`1111zz`) opcodes. On call it stores the return address (PC+1); on return it presents the stored address combinationally so the PC mux, steered by `s_stack`, can load it in the same cycle. It tracks occupancy and flags overflow/underflow stickily for debug.

## Interface
Parameters:
- `DEPTH`, 16, number of return-address entries (power of two, ≥2)
- `AW`, 10, address width (matches PC width)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset_n`  in  1  reset, synchronous, active-low
- `push`  in  1  call strobe from control unit
- `pop`  in  1  return strobe from control unit
- `ret_in`  in  AW  return address to store (PC+1)
- `ret_out`  out  AW  current top-of-stack address (combinational read)
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- `empty`  out  1  count == 0
- `full`  out  1  count == DEPTH
- `ovf`  out  1  sticky: push attempted while full
- `unf`  out  1  sticky: pop attempted while empty

## Operation
- State: storage array `mem[DEPTH]` of AW bits; stack pointer `sp` (= count), pointing to next free slot; sticky `ovf`, `unf`.
- `ret_out` = `mem[sp-1]` when `!empty`, else all zeros. Purely combinational from `sp` and array.
- Per cycle, decoded from {push, pop}:
  - 00: hold.
  - 10, not full: `mem[sp] <= ret_in`, `sp <= sp+1`.
  - 10, full: no write, `sp` unchanged, `ovf <= 1`.
  - 01, not empty: `sp <= sp-1`; array untouched.
  - 01, empty: `sp` unchanged, `unf <= 1`; `ret_out` stays 0.
  - 11, not empty: replace top: `mem[sp-1] <= ret_in`, `sp` unchanged.
  - 11, empty: behaves as push (write `mem[0]`, `sp <= 1`); `unf` not set.
- `sp` never wraps: saturates at 0 and DEPTH by the rules above.
- Array contents are not reset; only `sp` and flags are. Stale entries are never visible because `ret_out` is gated by `empty`.

## Timing
- Reset (`reset_n` low at rising edge): `sp`=0, `ovf`=0, `unf`=0; thus `count`=0, `empty`=1, `full`=0, `ret_out`=0. Reset has priority over push/pop in the same cycle; an operation in progress is discarded.
- Pop latency: zero cycles — `ret_out` valid in the cycle `pop` is asserted; `sp` decrements at that cycle's edge, so the next cycle shows the new top.
- Push latency: written value visible on `ret_out` the cycle after the edge.
- `count`, `empty`, `full` reflect registered `sp`; update one edge after the operation.
- `ovf`/`unf` set at the edge of the offending cycle; cleared only by reset.
- Inputs sampled only at rising edge; no handshake—control unit strobes are single-cycle and trusted.

## Structure
- Shared package `cpu_pkg`: `PC_W` (=10), `RSTACK_DEPTH` (=16), opcode constants `OP_PUSH` (`6'b1110??`) and `OP_POP` (`6'b1111??`) so control unit and stack agree on encodings.
- One sub-module natural: `stack_regfile` — DEPTH×AW register array, one synchronous write port (`we`, `waddr`, `wdata`), one combinational read port (`raddr`, `rdata`). Pointer logic and flags live in `return_stack`.

## Test plan
- Reset: drive push with `ret_in`=0x3FF while `reset_n`=0 → after edge `count`=0, `empty`=1, `ret_out`=0, flags 0.
- Push 0x010, 0x020, 0x030 then pop three times → `ret_out` reads 0x030, 0x020, 0x010 in the pop cycles; `empty`=1 after last pop, `unf`=0.
- Fill: 16 pushes of 0x100+i → `full`=1, `count`=16; 17th push 0x2AA → `ovf`=1, `ret_out` still 0x10F, `count`=16.
- Pop on empty after reset → `unf`=1, `ret_out`=0, `count`=0; following push 0x055 → `count`=1, `ret_out`=0x055, `unf` stays 1.
- Push 0x040, then push+pop with `ret_in`=0x077 → `count`=1, `ret_out`=0x077; push+pop on empty with 0x011 → `count`=1, `ret_out`=0x011, `unf`=0.
- Mid-sequence reset after 5 pushes → `count`=0, `empty`=1, flags cleared; subsequent push 0x001 → `ret_out`=0x001, `count`=1.
